// File: rtl/mul_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mul_sched                                                     |
// | Desc   : Two-port round-robin scheduler for a shared shift-add          |
// |          multiplier. MUL_SCHED_EARLY_DONE_EN ends the calculation once  |
// |          the remaining multiplier bits are all zero.                    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module mul_sched #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    output logic               gnt0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [2*WIDTH-1:0] p
);

    localparam logic [1:0]      c_IDLE = 2'd0;
    localparam logic [1:0]      c_CALC = 2'd1;
    localparam logic [1:0]      c_DONE = 2'd2;
    localparam logic [CNTW-1:0] c_LAST = CNTW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;
    logic               r_id;
    logic               r_lp;
    logic               r_busy;
    logic               r_done;
    logic               r_done_id;
    logic [2*WIDTH-1:0] r_p;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_mplr_nxt;
    logic               w_last;

    // r_lp is the last-served port: the other port wins a tie.
    assign w_idle = (r_state == c_IDLE);
    assign w_gnt0 = w_idle & req0 & (~req1 | r_lp);
    assign w_gnt1 = w_idle & req1 & (~req0 | ~r_lp);

    assign w_acc_nxt  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplr_nxt = r_mplr >> 1;

`ifdef MUL_SCHED_EARLY_DONE_EN
    assign w_last = (r_cnt == c_LAST) || (w_mplr_nxt == '0);
`else
    assign w_last = (r_cnt == c_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_id      <= 1'b0;
            r_lp      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_p       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (w_gnt0 || w_gnt1) begin
                        r_mcand <= {{WIDTH{1'b0}}, (w_gnt1 ? a1 : a0)};
                        r_mplr  <= w_gnt1 ? b1 : b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_id    <= w_gnt1;
                        r_lp    <= w_gnt1;
                        r_busy  <= 1'b1;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= w_mplr_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    // Product is captured on entry to DONE so p is valid with the pulse.
                    if (w_last) begin
                        r_p       <= w_acc_nxt;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign p       = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mul_sched                                                  |
// | Desc   : Self-checking bench for mul_sched with a behavioural model.   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_mul_sched;

    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0 = 1'b0;
    logic               req1 = 1'b0;
    logic [WIDTH-1:0]   a0 = '0;
    logic [WIDTH-1:0]   b0 = '0;
    logic [WIDTH-1:0]   a1 = '0;
    logic [WIDTH-1:0]   b1 = '0;
    logic               gnt0;
    logic               gnt1;
    logic               busy;
    logic               done;
    logic               done_id;
    logic [2*WIDTH-1:0] p;

    int checks = 0;
    int passed = 0;

    mul_sched #(.WIDTH(WIDTH), .CNTW(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .busy(busy), .done(done), .done_id(done_id), .p(p)
    );

    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] mul_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    endfunction

    // Cycles from grant to the done pulse.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MUL_SCHED_EARLY_DONE_EN
        int calc = 1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) calc = i + 1;
        return calc + 1;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Samples the grant for the currently driven requests, then follows the
    // operation to one cycle past its done pulse.
    task automatic observe(output logic g0, output logic g1, output int lat,
                           output logic [2*WIDTH-1:0] prod, output logic id,
                           output int bcnt, output int pulses, output int gnt_busy,
                           output logic [2*WIDTH-1:0] phold);
        #1;
        g0 = gnt0; g1 = gnt1;
        lat = -1; bcnt = 0; pulses = 0; gnt_busy = 0; prod = '0; id = 1'b0; phold = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                if (g0) req0 = 1'b0;
                if (g1) req1 = 1'b0;
            end
            #1;
            if (busy) bcnt++;
            if (busy && (gnt0 || gnt1)) gnt_busy++;
            if (done) begin
                pulses++;
                if (lat < 0) begin lat = n; prod = p; id = done_id; end
            end
            if (lat >= 0 && n == lat + 1) begin phold = p; break; end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (done_id !== 1'b0) $display("FAIL reset_done_id: got %b want 0", done_id); else passed++;
        checks++; if (p !== '0) $display("FAIL reset_p: got %h want 0", p); else passed++;
        checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic g0, g1, id;
        int lat, bcnt, pulses, gb;
        logic [2*WIDTH-1:0] prod, ph;
        req0 = 1'b1; a0 = 16'd50; b0 = 16'd50;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if ({g0, g1} !== 2'b10) $display("FAIL basic0_gnt: got %b want 10", {g0, g1}); else passed++;
        checks++; if (lat != exp_lat(16'd50)) $display("FAIL basic0_lat: got %0d want %0d", lat, exp_lat(16'd50)); else passed++;
        checks++; if (prod !== 32'd2500) $display("FAIL basic0_p: got %0d want 2500", prod); else passed++;
        checks++; if (id !== 1'b0) $display("FAIL basic0_id: got %b want 0", id); else passed++;
        req1 = 1'b1; a1 = 16'hFFFF; b1 = 16'hFFFF;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if ({g0, g1} !== 2'b01) $display("FAIL basic1_gnt: got %b want 01", {g0, g1}); else passed++;
        checks++; if (prod !== 32'hFFFE0001) $display("FAIL basic1_p: got %h want fffe0001", prod); else passed++;
        checks++; if (id !== 1'b1) $display("FAIL basic1_id: got %b want 1", id); else passed++;
        checks++; if (bcnt != exp_lat(16'hFFFF)) $display("FAIL basic1_busy: got %0d want %0d", bcnt, exp_lat(16'hFFFF)); else passed++;
        checks++; if (ph !== 32'hFFFE0001) $display("FAIL basic1_hold: got %h want fffe0001", ph); else passed++;
    endtask

    task automatic test_tie();
        logic g0, g1, id;
        int lat, bcnt, pulses, gb;
        logic [2*WIDTH-1:0] prod, ph;
        apply_reset();
        req0 = 1'b1; a0 = 16'd3; b0 = 16'd5;
        req1 = 1'b1; a1 = 16'd7; b1 = 16'd9;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if ({g0, g1} !== 2'b10) $display("FAIL tie1_gnt: got %b want 10", {g0, g1}); else passed++;
        checks++; if (prod !== 32'd15 || id !== 1'b0) $display("FAIL tie1_res: got %0d/%b want 15/0", prod, id); else passed++;
        checks++; if (gb != 0) $display("FAIL tie1_gnt_busy: got %0d want 0", gb); else passed++;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if ({g0, g1} !== 2'b01) $display("FAIL tie2_gnt: got %b want 01", {g0, g1}); else passed++;
        checks++; if (prod !== 32'd63 || id !== 1'b1) $display("FAIL tie2_res: got %0d/%b want 63/1", prod, id); else passed++;
        req0 = 1'b1; req1 = 1'b1;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if ({g0, g1} !== 2'b10) $display("FAIL tie3_gnt: got %b want 10", {g0, g1}); else passed++;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if (prod !== 32'd63 || id !== 1'b1) $display("FAIL tie4_res: got %0d/%b want 63/1", prod, id); else passed++;
    endtask

    task automatic test_operands();
        logic [WIDTH-1:0] ta [4] = '{16'd0, 16'd1234, 16'd9, 16'd3};
        logic [WIDTH-1:0] tb [4] = '{16'd1234, 16'd0, 16'd1, 16'd4};
        logic g0, g1, id;
        int lat, bcnt, pulses, gb;
        logic [2*WIDTH-1:0] prod, ph;
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; a0 = ta[i]; b0 = tb[i];
            observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
            checks++; if (prod !== mul_ref(ta[i], tb[i])) $display("FAIL oper%0d_p: got %0d want %0d", i, prod, mul_ref(ta[i], tb[i])); else passed++;
            checks++; if (lat != exp_lat(tb[i])) $display("FAIL oper%0d_lat: got %0d want %0d", i, lat, exp_lat(tb[i])); else passed++;
            checks++; if (pulses != 1) $display("FAIL oper%0d_pulses: got %0d want 1", i, pulses); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic g0, g1, id;
        int lat, bcnt, pulses, gb;
        logic [2*WIDTH-1:0] prod, ph;
        int seen = 0;
        req0 = 1'b1; a0 = 16'd100; b0 = 16'd200;
        #1;
        checks++; if (gnt0 !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", gnt0); else passed++;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            req0 = 1'b0;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_flags: got busy=%b done=%b want 0/0", busy, done); else passed++;
        checks++; if (p !== '0) $display("FAIL rstmid_p: got %h want 0", p); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #2;
            if (done || busy) seen++;
        end
        checks++; if (seen != 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen); else passed++;
        // A tie now shows whether the pointer returned to 1.
        req0 = 1'b1; req1 = 1'b1; a1 = 16'd5; b1 = 16'd5;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if ({g0, g1} !== 2'b10) $display("FAIL rstmid_after_gnt: got %b want 10", {g0, g1}); else passed++;
        checks++; if (prod !== 32'd20000) $display("FAIL rstmid_after_p: got %0d want 20000", prod); else passed++;
        observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
        checks++; if (prod !== 32'd25 || id !== 1'b1) $display("FAIL rstmid_after1: got %0d/%b want 25/1", prod, id); else passed++;
    endtask

    task automatic test_random();
        logic g0, g1, id;
        int lat, bcnt, pulses, gb;
        logic [2*WIDTH-1:0] prod, ph;
        bit pend0 = 1'b0, pend1 = 1'b0;
        bit lp_m = 1'b1;
        bit w;
        logic [WIDTH-1:0] wa, wb;
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1; a0 = WIDTH'($urandom);
                b0 = ($urandom_range(0, 3) == 0) ? WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : WIDTH'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1; a1 = WIDTH'($urandom);
                b1 = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom >> $urandom_range(0, 31));
            end
            if (!pend0 && !pend1) begin
                pend0 = 1'b1; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
            end
            req0 = pend0; req1 = pend1;
            w  = (pend0 && pend1) ? !lp_m : pend1;
            wa = w ? a1 : a0;
            wb = w ? b1 : b0;
            observe(g0, g1, lat, prod, id, bcnt, pulses, gb, ph);
            checks++; if ({g0, g1} !== (w ? 2'b01 : 2'b10)) $display("FAIL rnd%0d_gnt: got %b want %b", it, {g0, g1}, (w ? 2'b01 : 2'b10)); else passed++;
            checks++; if (prod !== mul_ref(wa, wb)) $display("FAIL rnd%0d_p: got %h want %h", it, prod, mul_ref(wa, wb)); else passed++;
            checks++; if (id !== w) $display("FAIL rnd%0d_id: got %b want %b", it, id, w); else passed++;
            checks++; if (lat != exp_lat(wb) || bcnt != exp_lat(wb)) $display("FAIL rnd%0d_lat: got lat=%0d busy=%0d want %0d", it, lat, bcnt, exp_lat(wb)); else passed++;
            checks++; if (pulses != 1 || gb != 0) $display("FAIL rnd%0d_proto: got pulses=%0d busy_gnts=%0d want 1/0", it, pulses, gb); else passed++;
            checks++; if (ph !== mul_ref(wa, wb)) $display("FAIL rnd%0d_hold: got %h want %h", it, ph, mul_ref(wa, wb)); else passed++;
            lp_m = w;
            if (w) pend1 = 1'b0; else pend0 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_operands();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Sequential shift-add multiply unit with a built-in two-port round-robin scheduler.
- Lets two ALU requesters share one WIDTH x WIDTH unsigned multiplier datapath.
- Each operation uses one adder pass per cycle instead of a full combinational partial-product array.
- Sits beside the ALU adder/multiplier blocks; results are tagged with the id of the requester that issued them.

Parameters:
- WIDTH, 16, operand width in bits; product width is 2*WIDTH.
- CNTW, 5, width of the iteration counter; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  requester 0 operation request; held high until gnt0 is seen.
- a0  input  WIDTH  requester 0 multiplicand; stable while req0 is high.
- b0  input  WIDTH  requester 0 multiplier; stable while req0 is high.
- gnt0  output  1  requester 0 accepted; combinational, one cycle wide.
- req1  input  1  requester 1 request; same rules as req0.
- a1  input  WIDTH  requester 1 multiplicand.
- b1  input  WIDTH  requester 1 multiplier.
- gnt1  output  1  requester 1 accepted.
- busy  output  1  high in CALC and DONE states.
- done  output  1  one-cycle pulse; p and done_id are valid in that cycle.
- done_id  output  1  requester id of the completed operation.
- p  output  2*WIDTH  product; holds its value until the next done.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; gnt0=gnt1=0; busy=0; done=0; done_id=0; p=0; last-served pointer lp=1, so port 0 wins the first tie.
- State IDLE:
  - gntK = reqK and (not req(1-K) or lp != K).
  - Exactly one gnt is high if any req is high; no gnt is high if no req is high.
  - On the edge ending a granted cycle:
    - mcand <= {WIDTH zeros, aK}
    - mplr <= bK
    - acc <= 0
    - cnt <= 0
    - id <= K
    - lp <= K
    - state <= CALC.
- State CALC, each cycle:
  - if mplr[0], acc <= acc + mcand, at 2*WIDTH bits; no carry-out is possible.
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt + 1.
  - Leave for DONE after the cycle in which cnt == WIDTH-1.
  - Exactly WIDTH CALC cycles in the base build.
- State DONE, one cycle: done=1, p=acc (registered on entry), done_id=id. Next state is IDLE.
- Latency: grant in cycle T gives done in cycle T+WIDTH+1. The earliest next grant is cycle T+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- Requests during CALC/DONE: gnt0=gnt1=0. Requests stay pending and are arbitrated in IDLE.
- Dropped request: a request dropped before its grant is simply lost; no state is kept for it.
- Arithmetic: unsigned only; p = a*b exactly, mod 2^(2*WIDTH) never needed.
- Reset mid-operation:
  - Immediately returns to IDLE with all outputs at reset values.
  - The in-flight operation is discarded and no done is issued.
  - lp returns to 1.
- Simultaneous requests in IDLE: the port != lp is granted; the other waits at least WIDTH+2 cycles.
- Back-to-back from one port: if only that port requests, it is granted again regardless of lp.

Optional Feature:
- Macro: MUL_SCHED_EARLY_DONE_EN.
- When defined:
  - CALC also exits to DONE after any cycle whose next mplr value (mplr >> 1) is zero.
  - At least one CALC cycle always runs.
  - Latency becomes (index of highest set bit of b)+1 CALC cycles, and 1 CALC cycle for b=0.
  - Product is unchanged.
- When undefined: always exactly WIDTH CALC cycles.

Test Plan:
- Reset, then req0 with a0=50, b0=50 -> gnt0 in cycle 0; done in cycle 17; p=32'd2500; done_id=0.
- req1 with a1=16'hFFFF, b1=16'hFFFF -> p=32'hFFFE0001; done_id=1; busy high for exactly 17 cycles.
- Tie after reset: req0 (3x5) and req1 (7x9) together:
  - gnt0 first, p=15, done_id=0.
  - next IDLE cycle gives gnt1, p=63, done_id=1.
  - Repeat the tie -> gnt0 again, because lp=1.
- Zero operands: a0=0, b0=1234 -> p=0. Also a0=1234, b0=0 -> p=0. Base build: 16 CALC cycles each.
- Reset mid-operation: assert rst in the 8th CALC cycle of 100x200 -> busy=0, done never pulses, p=0. A new request afterward completes correctly.
- With MUL_SCHED_EARLY_DONE_EN: a0=9, b0=1 -> done 2 cycles after grant, p=9. a0=3, b0=16'h0004 -> done 4 cycles after grant, p=12.
